// File: rtl/txtsu_collector.sv
// TX timestamp collector: two-state acknowledge handshake feeding a first-word-fall-through FIFO.
// Optional drop counter on ovf_cnt_o is built when TXTSU_COLLECTOR_OVF_CNT_EN is defined.
module txtsu_collector #(
    parameter int unsigned g_fifo_depth = 8
) (
    input  logic                            clk_sys_i,
    input  logic                            rst_i,
    input  logic                            txtsu_valid_i,
    input  logic [4:0]                      txtsu_port_id_i,
    input  logic [15:0]                     txtsu_frame_id_i,
    input  logic [31:0]                     txtsu_ts_i,
    output logic                            txtsu_ack_o,
    output logic                            rd_valid_o,
    input  logic                            rd_ack_i,
    output logic [4:0]                      rd_port_id_o,
    output logic [15:0]                     rd_frame_id_o,
    output logic [31:0]                     rd_ts_o,
    output logic [$clog2(g_fifo_depth):0]   count_o,
    output logic                            ovf_o,
    input  logic                            ovf_clr_i,
    output logic [15:0]                     ovf_cnt_o
);

    localparam int unsigned c_aw = $clog2(g_fifo_depth);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(g_fifo_depth);

    typedef enum logic {IDLE, ACK} state_t;

    state_t           state;
    logic [52:0]      mem [g_fifo_depth];
    logic [c_aw-1:0]  wr_ptr;
    logic [c_aw-1:0]  rd_ptr;
    logic [c_aw-1:0]  rd_next;
    logic [c_aw:0]    count;
    logic [c_aw:0]    remain;
    logic             capture;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;

    always_comb begin
        capture = (state == IDLE) && txtsu_valid_i;
        pop     = rd_ack_i && rd_valid_o;
        full    = (count == c_depth);
        wr_en   = capture && (!full || pop);
        drop    = capture && full && !pop;
        // entries that survive this edge and were written before it; only these may be shown
        remain  = count - (c_aw + 1)'(pop);
        rd_next = rd_ptr + c_aw'(pop);
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            txtsu_ack_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txtsu_ack_o <= 1'b0;
                    if (txtsu_valid_i) begin
                        state       <= ACK;
                        txtsu_ack_o <= 1'b1;
                    end
                end
                ACK: begin
                    state       <= IDLE;
                    txtsu_ack_o <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    txtsu_ack_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (wr_en)
            mem[wr_ptr] <= {txtsu_port_id_i, txtsu_frame_id_i, txtsu_ts_i};
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rd_valid_o    <= 1'b0;
            rd_port_id_o  <= '0;
            rd_frame_id_o <= '0;
            rd_ts_o       <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_next;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rd_valid_o <= (remain != '0);
            if (remain != '0)
                {rd_port_id_o, rd_frame_id_o, rd_ts_o} <= mem[rd_next];
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i)
            ovf_o <= 1'b0;
        else if (ovf_clr_i)
            ovf_o <= 1'b0;
        else if (drop)
            ovf_o <= 1'b1;
    end

`ifdef TXTSU_COLLECTOR_OVF_CNT_EN
    logic [15:0] ovf_cnt;

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i)
            ovf_cnt <= '0;
        else if (ovf_clr_i)
            ovf_cnt <= '0;
        else if (drop && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + 1'b1;
    end

    assign ovf_cnt_o = ovf_cnt;
`else
    assign ovf_cnt_o = '0;
`endif

    assign count_o = count;

endmodule

// File: tb/tb_txtsu_collector.sv
// Self-checking bench for txtsu_collector: directed scenarios plus randomized traffic against a queue model.
module tb_txtsu_collector;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef TXTSU_COLLECTOR_OVF_CNT_EN
    localparam bit OVF_CNT_ON = 1'b1;
`else
    localparam bit OVF_CNT_ON = 1'b0;
`endif

    typedef logic [52:0] entry_t;

    logic          clk_sys_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          txtsu_valid_i = 1'b0;
    logic [4:0]    txtsu_port_id_i = '0;
    logic [15:0]   txtsu_frame_id_i = '0;
    logic [31:0]   txtsu_ts_i = '0;
    logic          txtsu_ack_o;
    logic          rd_valid_o;
    logic          rd_ack_i = 1'b0;
    logic [4:0]    rd_port_id_o;
    logic [15:0]   rd_frame_id_o;
    logic [31:0]   rd_ts_o;
    logic [CW-1:0] count_o;
    logic          ovf_o;
    logic          ovf_clr_i = 1'b0;
    logic [15:0]   ovf_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_seen = 0;

    // reference model: queue of stored entries plus handshake/overflow bookkeeping
    entry_t mq[$];
    bit     m_busy;
    bit     m_fresh;
    bit     m_ovf;
    int     m_cnt;

    txtsu_collector #(.g_fifo_depth(DEPTH)) dut (
        .clk_sys_i        (clk_sys_i),
        .rst_i            (rst_i),
        .txtsu_valid_i    (txtsu_valid_i),
        .txtsu_port_id_i  (txtsu_port_id_i),
        .txtsu_frame_id_i (txtsu_frame_id_i),
        .txtsu_ts_i       (txtsu_ts_i),
        .txtsu_ack_o      (txtsu_ack_o),
        .rd_valid_o       (rd_valid_o),
        .rd_ack_i         (rd_ack_i),
        .rd_port_id_o     (rd_port_id_o),
        .rd_frame_id_o    (rd_frame_id_o),
        .rd_ts_o          (rd_ts_o),
        .count_o          (count_o),
        .ovf_o            (ovf_o),
        .ovf_clr_i        (ovf_clr_i),
        .ovf_cnt_o        (ovf_cnt_o)
    );

    always #5 clk_sys_i = ~clk_sys_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_visible();
        return (int'(mq.size()) - int'(m_fresh)) > 0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy  = 0;
        m_fresh = 0;
        m_ovf   = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        bit accept, pop, full, drop, wrote;
        accept = txtsu_valid_i && !m_busy;
        pop    = rd_ack_i && m_visible();
        full   = (mq.size() == DEPTH);
        drop   = 0;
        wrote  = 0;
        if (pop) void'(mq.pop_front());
        if (accept) begin
            if (!full || pop) begin
                mq.push_back({txtsu_port_id_i, txtsu_frame_id_i, txtsu_ts_i});
                wrote = 1;
            end else begin
                drop = 1;
            end
        end
        m_fresh = wrote;
        m_busy  = accept;
        if (ovf_clr_i) m_ovf = 0;
        else if (drop) m_ovf = 1;
        if (OVF_CNT_ON) begin
            if (ovf_clr_i) m_cnt = 0;
            else if (drop && m_cnt < 16'hFFFF) m_cnt++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_sys_i);
        #1;
        if (txtsu_ack_o) ack_seen++;
    endtask

    task automatic send_event(input logic [4:0] p, input logic [15:0] f, input logic [31:0] t);
        txtsu_port_id_i  = p;
        txtsu_frame_id_i = f;
        txtsu_ts_i       = t;
        txtsu_valid_i    = 1'b1;
        tick();
        txtsu_valid_i    = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_sys_i);
        #1;
        n_checks++;
        if ({txtsu_ack_o, rd_valid_o, ovf_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got ack/valid/ovf=%b expected 000", {txtsu_ack_o, rd_valid_o, ovf_o});
        end
        n_checks++;
        if (count_o !== '0 || ovf_cnt_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counts: got count=%0d ovf_cnt=%0d expected 0 0", count_o, ovf_cnt_o);
        end
        n_checks++;
        if ({rd_port_id_o, rd_frame_id_o, rd_ts_o} !== 53'h0) begin
            n_fail++;
            $display("FAIL reset_rd_fields: got %h expected 0", {rd_port_id_o, rd_frame_id_o, rd_ts_o});
        end
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        txtsu_port_id_i  = 5'd3;
        txtsu_frame_id_i = 16'h1234;
        txtsu_ts_i       = 32'hDEADBEEF;
        txtsu_valid_i    = 1'b1;
        tick();
        n_checks++;
        if (txtsu_ack_o !== 1'b1 || rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: got ack=%b valid=%b expected 1 0", txtsu_ack_o, rd_valid_o);
        end
        tick();
        txtsu_valid_i = 1'b0;
        n_checks++;
        if (txtsu_ack_o !== 1'b0 || rd_valid_o !== 1'b1 || count_o !== CW'(1)) begin
            n_fail++;
            $display("FAIL single_fwft: got ack=%b valid=%b count=%0d expected 0 1 1", txtsu_ack_o, rd_valid_o, count_o);
        end
        n_checks++;
        if (rd_port_id_o !== 5'd3 || rd_frame_id_o !== 16'h1234 || rd_ts_o !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_fields: got %0d/%h/%h expected 3/1234/deadbeef", rd_port_id_o, rd_frame_id_o, rd_ts_o);
        end
        rd_ack_i = 1'b1;
        tick();
        rd_ack_i = 1'b0;
        n_checks++;
        if (count_o !== '0 || rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: got count=%0d valid=%b expected 0 0", count_o, rd_valid_o);
        end
    endtask

    task automatic test_held_valid();
        ack_seen = 0;
        txtsu_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            txtsu_port_id_i  = 5'($urandom);
            txtsu_frame_id_i = 16'h0500 + 16'(i);
            txtsu_ts_i       = $urandom;
            tick();
        end
        txtsu_valid_i = 1'b0;
        n_checks++;
        if (ack_seen != 5 || count_o !== CW'(5)) begin
            n_fail++;
            $display("FAIL held_valid: got acks=%0d count=%0d expected 5 5", ack_seen, count_o);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rd_valid_o !== 1'b1 || rd_frame_id_o !== 16'h0500 + 16'(2 * i)) begin
                n_fail++;
                $display("FAIL held_read%0d: got valid=%b frame=%h expected 1 %h", i, rd_valid_o, rd_frame_id_o, 16'h0500 + 16'(2 * i));
            end
            rd_ack_i = 1'b1;
            tick();
            rd_ack_i = 1'b0;
        end
    endtask

    task automatic test_overflow();
        ack_seen = 0;
        for (int i = 0; i < 10; i++) send_event(5'(i), 16'h0100 + 16'(i), 32'(i * 7));
        n_checks++;
        if (ack_seen != 10 || count_o !== CW'(DEPTH) || ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_state: got acks=%0d count=%0d ovf=%b expected 10 8 1", ack_seen, count_o, ovf_o);
        end
        n_checks++;
        if (ovf_cnt_o !== (OVF_CNT_ON ? 16'd2 : 16'd0)) begin
            n_fail++;
            $display("FAIL overflow_cnt: got %0d expected %0d", ovf_cnt_o, OVF_CNT_ON ? 2 : 0);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_valid_o !== 1'b1 || rd_frame_id_o !== 16'h0100 + 16'(i)) begin
                n_fail++;
                $display("FAIL overflow_read%0d: got valid=%b frame=%h expected 1 %h", i, rd_valid_o, rd_frame_id_o, 16'h0100 + 16'(i));
            end
            rd_ack_i = 1'b1;
            tick();
            rd_ack_i = 1'b0;
        end
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        n_checks++;
        if (ovf_o !== 1'b0 || ovf_cnt_o !== 16'h0 || count_o !== '0) begin
            n_fail++;
            $display("FAIL overflow_clear: got ovf=%b cnt=%0d count=%0d expected 0 0 0", ovf_o, ovf_cnt_o, count_o);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 8; i++) send_event(5'd1, 16'h0200 + 16'(i), 32'h1000 + 32'(i));
        txtsu_frame_id_i = 16'h02FF;
        txtsu_valid_i    = 1'b1;
        rd_ack_i         = 1'b1;
        tick();
        txtsu_valid_i    = 1'b0;
        rd_ack_i         = 1'b0;
        tick();
        n_checks++;
        if (count_o !== CW'(DEPTH) || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_state: got count=%0d ovf=%b expected 8 0", count_o, ovf_o);
        end
        for (int i = 0; i < 8; i++) begin
            logic [15:0] exp_f;
            exp_f = (i == 7) ? 16'h02FF : 16'h0201 + 16'(i);
            n_checks++;
            if (rd_valid_o !== 1'b1 || rd_frame_id_o !== exp_f) begin
                n_fail++;
                $display("FAIL full_pop_read%0d: got valid=%b frame=%h expected 1 %h", i, rd_valid_o, rd_frame_id_o, exp_f);
            end
            rd_ack_i = 1'b1;
            tick();
            rd_ack_i = 1'b0;
        end
    endtask

    task automatic test_ovf_clr_same_cycle();
        for (int i = 0; i < 8; i++) send_event(5'd2, 16'h0300 + 16'(i), 32'(i));
        txtsu_valid_i = 1'b1;
        ovf_clr_i     = 1'b1;
        tick();
        txtsu_valid_i = 1'b0;
        ovf_clr_i     = 1'b0;
        n_checks++;
        if (ovf_o !== 1'b0 || ovf_cnt_o !== 16'h0 || count_o !== CW'(DEPTH)) begin
            n_fail++;
            $display("FAIL ovf_clr_priority: got ovf=%b cnt=%0d count=%0d expected 0 0 8", ovf_o, ovf_cnt_o, count_o);
        end
        tick();
        send_event(5'd2, 16'h03AA, 32'h0);
        n_checks++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_after_clr: got %b expected 1", ovf_o);
        end
        for (int i = 0; i < 20 && rd_valid_o; i++) begin
            rd_ack_i = 1'b1;
            tick();
        end
        rd_ack_i  = 1'b0;
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        n_checks++;
        if (count_o !== '0 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr_drain: got count=%0d ovf=%b expected 0 0", count_o, ovf_o);
        end
    endtask

    task automatic test_reset_mid_ack();
        send_event(5'd4, 16'h0400, 32'h1);
        send_event(5'd4, 16'h0401, 32'h2);
        txtsu_frame_id_i = 16'h0402;
        txtsu_valid_i    = 1'b1;
        tick();
        txtsu_valid_i    = 1'b0;
        n_checks++;
        if (txtsu_ack_o !== 1'b1 || count_o !== CW'(3)) begin
            n_fail++;
            $display("FAIL mid_ack_setup: got ack=%b count=%0d expected 1 3", txtsu_ack_o, count_o);
        end
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (txtsu_ack_o !== 1'b0 || count_o !== '0 || rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ack_reset: got ack=%b count=%0d valid=%b expected 0 0 0", txtsu_ack_o, count_o, rd_valid_o);
        end
        #2;
        rst_i = 1'b0;
        model_reset();
        txtsu_port_id_i  = 5'd9;
        txtsu_frame_id_i = 16'h0499;
        txtsu_valid_i    = 1'b1;
        tick();
        txtsu_valid_i    = 1'b0;
        n_checks++;
        if (txtsu_ack_o !== 1'b1 || count_o !== CW'(1)) begin
            n_fail++;
            $display("FAIL post_reset_event: got ack=%b count=%0d expected 1 1", txtsu_ack_o, count_o);
        end
        tick();
        n_checks++;
        if (rd_valid_o !== 1'b1 || rd_frame_id_o !== 16'h0499) begin
            n_fail++;
            $display("FAIL post_reset_read: got valid=%b frame=%h expected 1 0499", rd_valid_o, rd_frame_id_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            txtsu_valid_i    = ($urandom_range(0, 99) < 65);
            rd_ack_i         = ($urandom_range(0, 99) < 35);
            ovf_clr_i        = ($urandom_range(0, 99) < 4);
            txtsu_port_id_i  = 5'($urandom);
            txtsu_frame_id_i = 16'($urandom);
            txtsu_ts_i       = $urandom;
            tick();
            n_checks++;
            if (txtsu_ack_o !== m_busy || count_o !== CW'(mq.size())) begin
                n_fail++;
                $display("FAIL rand_ack_count c=%0d: got ack=%b count=%0d expected %b %0d", c, txtsu_ack_o, count_o, m_busy, mq.size());
            end
            n_checks++;
            if (rd_valid_o !== m_visible()) begin
                n_fail++;
                $display("FAIL rand_valid c=%0d: got %b expected %b", c, rd_valid_o, m_visible());
            end
            if (m_visible()) begin
                n_checks++;
                if ({rd_port_id_o, rd_frame_id_o, rd_ts_o} !== mq[0]) begin
                    n_fail++;
                    $display("FAIL rand_head c=%0d: got %h expected %h", c, {rd_port_id_o, rd_frame_id_o, rd_ts_o}, mq[0]);
                end
            end
            n_checks++;
            if (ovf_o !== m_ovf || ovf_cnt_o !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL rand_ovf c=%0d: got ovf=%b cnt=%0d expected %b %0d", c, ovf_o, ovf_cnt_o, m_ovf, m_cnt);
            end
        end
        txtsu_valid_i = 1'b0;
        rd_ack_i      = 1'b0;
        ovf_clr_i     = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_held_valid();
        test_overflow();
        test_full_pop();
        test_ovf_clr_same_cycle();
        test_reset_mid_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/txtsu_collector.md
TXTSU_COLLECTOR -- requirements
Module: txtsu_collector

Interface
REQ-001 The block SHALL have parameter g_fifo_depth, default 8, meaning the number of buffered timestamp entries (a power of 2, range 2..64).
REQ-002 The block SHALL have port clk_sys_i, input, width 1: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_i, input, width 1: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port txtsu_valid_i, input, width 1: the endpoint asserts this while a TX timestamp is offered.
REQ-005 The block SHALL have port txtsu_port_id_i, input, width 5: the port identifier of the offered timestamp.
REQ-006 The block SHALL have port txtsu_frame_id_i, input, width 16: the frame identifier of the offered timestamp.
REQ-007 The block SHALL have port txtsu_ts_i, input, width 32: the timestamp value.
REQ-008 The block SHALL have port txtsu_ack_o, output, width 1: the one-cycle acknowledge back to the endpoint.
REQ-009 The block SHALL have port rd_valid_o, output, width 1: the head FIFO entry is present on the rd_* outputs.
REQ-010 The block SHALL have port rd_ack_i, input, width 1: pops the head entry.
REQ-011 The block SHALL have ports rd_port_id_o (5), rd_frame_id_o (16) and rd_ts_o (32), all outputs, carrying the head entry fields.
REQ-012 The block SHALL have port count_o, output, width clog2(g_fifo_depth)+1: the number of stored entries.
REQ-013 The block SHALL have port ovf_o, output, width 1: a sticky flag set when an entry was dropped.
REQ-014 The block SHALL have port ovf_clr_i, input, width 1: clears ovf_o, and also ovf_cnt_o when that feature is built.
REQ-015 The block SHALL have port ovf_cnt_o, output, width 16: the drop counter (see Configuration).

Function
REQ-016 The handshake FSM SHALL have two states: IDLE and ACK.
REQ-017 In IDLE, on a rising edge with txtsu_valid_i=1, the block SHALL capture the port_id, frame_id and ts inputs and move to ACK.
REQ-018 In ACK, txtsu_ack_o SHALL be 1 for exactly one cycle, txtsu_valid_i SHALL be ignored, and the FSM SHALL return to IDLE unconditionally.
REQ-019 The minimum spacing between accepted events SHALL be 2 cycles: a valid held high across the ACK cycle counts as a new event only from the following IDLE cycle.
REQ-020 A capture SHALL write the FIFO on the same edge; rd_valid_o SHALL go to 1 on the next cycle when the FIFO was empty (first-word fall-through).
REQ-021 A capture while the FIFO is full and rd_ack_i=0 SHALL still be acknowledged, SHALL discard the entry, and SHALL set ovf_o.
REQ-022 A capture and a pop in the same cycle with the FIFO full SHALL be accepted, leaving count_o unchanged.
REQ-023 rd_ack_i while rd_valid_o=0 SHALL be ignored; a capture and a pop in the same cycle with the FIFO empty SHALL store the entry (count_o becomes 1).
REQ-024 The pointers SHALL wrap modulo g_fifo_depth; count_o SHALL never exceed g_fifo_depth.
REQ-025 rd_*_o SHALL be held stable while rd_valid_o=1 and no pop occurs.
REQ-026 ovf_clr_i SHALL take priority over a simultaneous overflow event in the same cycle (the flag ends cleared).

Reset
REQ-027 When rst_i is asserted, the block SHALL immediately set: FSM=IDLE, txtsu_ack_o=0, rd_valid_o=0, count_o=0, pointers=0, ovf_o=0, ovf_cnt_o=0 and rd_*_o=0.
REQ-028 A reset asserted mid-handshake SHALL abort the ACK, and FIFO contents SHALL be lost.
REQ-029 After reset is deasserted, the first valid seen SHALL be treated as a new event.

Configuration
REQ-030 The macro TXTSU_COLLECTOR_OVF_CNT_EN, when defined, SHALL make ovf_cnt_o count dropped entries, saturating at 0xFFFF, and cleared by ovf_clr_i.
REQ-031 When TXTSU_COLLECTOR_OVF_CNT_EN is undefined, ovf_cnt_o SHALL be tied to 0 and no counter logic shall exist; all other behaviour is unchanged.

Verification
REQ-032 The bench SHALL cover this directed case: valid held with port 3, frame 0x1234, ts 0xDEADBEEF -> ack is exactly 1 cycle, and one cycle later rd_valid_o=1 with the same fields and count_o=1.
REQ-033 The bench SHALL cover this directed case: valid held high for 10 cycles -> 5 acks, 5 entries, and count_o=5.
REQ-034 The bench SHALL cover this directed case: with depth 8, 10 events and no reads -> 10 acks, count_o=8, ovf_o=1, ovf_cnt_o=2 (macro on) or 0 (macro off), and the entries read out are the first 8 frame_ids in order.
REQ-035 The bench SHALL cover this directed case: FIFO full, then a capture and rd_ack_i in the same cycle -> count_o stays 8, ovf_o stays 0, and the new entry is read last.
REQ-036 The bench SHALL cover this directed case: rst_i pulsed during the ACK cycle with 3 entries stored -> immediately ack=0, count_o=0 and rd_valid_o=0; a next event is accepted normally.
REQ-037 The bench SHALL cover this directed case: ovf_clr_i asserted on the same cycle as an overflow -> ovf_o=0 afterwards.
